// File: rtl/lc3_control_fsm.sv
// LC-3 multi-cycle control sequencer.
// It fetches one instruction, decodes it, then either executes it in one
// cycle or runs one memory access using a req/ready handshake.
// HALT and FAULT are terminal states that only rst can leave.
module lc3_control_fsm #(
  parameter int unsigned WAIT_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic [2:0]  nzp,
  input  logic        mem_ready,
  output logic [1:0]  pc_sel,
  output logic        alu_b_sel,
  output logic        mem_to_reg,
  output logic [1:0]  alu_op,
  output logic        ir_load,
  output logic        pc_load,
  output logic        reg_write,
  output logic        cc_load,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        halted,
  output logic        fault
);

  // A timeout of 0 disables the timeout, but the counter still keeps a 1-bit floor
  localparam int unsigned CNT_W = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM_RD,
    S_MEM_WR,
    S_HALT,
    S_FAULT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q;
  logic [3:0]       opcode;
  logic             timeout_hit;
  logic [CNT_W-1:0] cnt_inc;
  logic             unused_instr;

  assign opcode       = instr[15:12];
  assign unused_instr = ^{instr[8:6], instr[4:0]};

  // The timeout fires on the cycle whose missing ready would take the count to WAIT_TIMEOUT
  assign timeout_hit = (WAIT_TIMEOUT != 0) && (cnt_q == CNT_W'(WAIT_TIMEOUT - 1));
  assign cnt_inc     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  // State, wait counter, and a run flag that holds every output at 0 until the first edge after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      run_q   <= 1'b1;
    end
  end

  // Next state, next counter value, and the control outputs for the current state
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    pc_sel     = 2'b00;
    alu_b_sel  = 1'b0;
    mem_to_reg = 1'b0;
    alu_op     = 2'b00;
    ir_load    = 1'b0;
    pc_load    = 1'b0;
    reg_write  = 1'b0;
    cc_load    = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    halted     = 1'b0;
    fault      = 1'b0;

    if (!run_q) begin
      state_d = S_FETCH;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_load = 1'b1;
            pc_load = 1'b1;
            state_d = S_DECODE;
          end else if (timeout_hit) begin
            state_d = S_FAULT;
          end else begin
            cnt_d = cnt_inc;
          end
        end

        S_DECODE: begin
          case (opcode)
            OP_ADD, OP_AND, OP_NOT, OP_BR, OP_JMP: state_d = S_EXEC;
            OP_LD, OP_LDR:                         state_d = S_MEM_RD;
            OP_ST, OP_STR:                         state_d = S_MEM_WR;
            OP_TRAP:                               state_d = S_HALT;
            default:                               state_d = S_FAULT;
          endcase
        end

        S_EXEC: begin
          state_d = S_FETCH;
          case (opcode)
            OP_ADD: begin
              alu_op    = 2'b00;
              alu_b_sel = instr[5];
              reg_write = 1'b1;
              cc_load   = 1'b1;
            end
            OP_AND: begin
              alu_op    = 2'b01;
              alu_b_sel = instr[5];
              reg_write = 1'b1;
              cc_load   = 1'b1;
            end
            OP_NOT: begin
              alu_op    = 2'b10;
              reg_write = 1'b1;
              cc_load   = 1'b1;
            end
            OP_BR: begin
              pc_sel  = 2'b01;
              pc_load = |(instr[11:9] & nzp);
            end
            OP_JMP: begin
              pc_sel  = 2'b10;
              pc_load = 1'b1;
            end
            default: ;
          endcase
        end

        S_MEM_RD: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          if (mem_ready) begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
            cc_load    = 1'b1;
            state_d    = S_FETCH;
          end else if (timeout_hit) begin
            state_d = S_FAULT;
          end else begin
            cnt_d = cnt_inc;
          end
        end

        S_MEM_WR: begin
          mem_req  = 1'b1;
          mem_we   = 1'b1;
          addr_sel = 1'b1;
          if (mem_ready) begin
            state_d = S_FETCH;
          end else if (timeout_hit) begin
            state_d = S_FAULT;
          end else begin
            cnt_d = cnt_inc;
          end
        end

        S_HALT:  halted = 1'b1;
        S_FAULT: fault  = 1'b1;
        default: state_d = S_FAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Directed bench for lc3_control_fsm: a default instance (timeout 16) and a
// second instance with timeout 4. Both share the same stimulus.
module tb_lc3_control_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic [2:0]  nzp;
  logic        mem_ready;

  logic [1:0] pc_sel, pc_sel4, alu_op, alu_op4;
  logic alu_b_sel, mem_to_reg, ir_load, pc_load, reg_write, cc_load;
  logic mem_req, mem_we, addr_sel, halted, fault;
  logic alu_b_sel4, mem_to_reg4, ir_load4, pc_load4, reg_write4, cc_load4;
  logic mem_req4, mem_we4, addr_sel4, halted4, fault4;

  int n_checks = 0;
  int n_err    = 0;

  // Output bit order: {pc_sel, alu_b_sel, mem_to_reg, alu_op, ir_load, pc_load,
  //                    reg_write, cc_load, mem_req, mem_we, addr_sel, halted, fault}
  logic [14:0] obs, obs4;
  assign obs  = {pc_sel, alu_b_sel, mem_to_reg, alu_op, ir_load, pc_load,
                 reg_write, cc_load, mem_req, mem_we, addr_sel, halted, fault};
  assign obs4 = {pc_sel4, alu_b_sel4, mem_to_reg4, alu_op4, ir_load4, pc_load4,
                 reg_write4, cc_load4, mem_req4, mem_we4, addr_sel4, halted4, fault4};

  localparam logic [14:0] O_ZERO       = 15'h0000;
  localparam logic [14:0] O_FETCH_WAIT = 15'h0010;
  localparam logic [14:0] O_FETCH_DONE = 15'h0190;
  localparam logic [14:0] O_RD_WAIT    = 15'h0014;
  localparam logic [14:0] O_RD_DONE    = 15'h0874;
  localparam logic [14:0] O_WR         = 15'h001C;
  localparam logic [14:0] O_HALT       = 15'h0002;
  localparam logic [14:0] O_FAULT      = 15'h0001;

  lc3_control_fsm dut (
    .clk(clk), .rst(rst), .instr(instr), .nzp(nzp), .mem_ready(mem_ready),
    .pc_sel(pc_sel), .alu_b_sel(alu_b_sel), .mem_to_reg(mem_to_reg), .alu_op(alu_op),
    .ir_load(ir_load), .pc_load(pc_load), .reg_write(reg_write), .cc_load(cc_load),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .halted(halted), .fault(fault)
  );

  lc3_control_fsm #(.WAIT_TIMEOUT(4)) dut4 (
    .clk(clk), .rst(rst), .instr(instr), .nzp(nzp), .mem_ready(mem_ready),
    .pc_sel(pc_sel4), .alu_b_sel(alu_b_sel4), .mem_to_reg(mem_to_reg4), .alu_op(alu_op4),
    .ir_load(ir_load4), .pc_load(pc_load4), .reg_write(reg_write4), .cc_load(cc_load4),
    .mem_req(mem_req4), .mem_we(mem_we4), .addr_sel(addr_sel4), .halted(halted4), .fault(fault4)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for one edge; return just after release, before the first run edge
  task automatic do_reset();
    rst       = 1'b1;
    mem_ready = 1'b0;
    instr     = 16'h0000;
    nzp       = 3'b000;
    #2;
    tick();
    rst = 1'b0;
  endtask

  // Starting in FETCH: fetch with immediate ready, pass through DECODE, and stop at the next state
  task automatic fetch_decode(input logic [15:0] i);
    instr     = i;
    mem_ready = 1'b1;
    #1;
    n_checks++;
    if (obs !== O_FETCH_DONE) begin
      n_err++;
      $display("FAIL fetch_%h: got %h expected %h", i, obs, O_FETCH_DONE);
    end
    tick();
    mem_ready = 1'b1;
    #1;
    n_checks++;
    if (obs !== O_ZERO) begin
      n_err++;
      $display("FAIL decode_%h: got %h expected %h", i, obs, O_ZERO);
    end
    mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (obs !== O_ZERO || obs4 !== O_ZERO) begin
      n_err++;
      $display("FAIL reset_idle: got %h/%h expected %h", obs, obs4, O_ZERO);
    end
    tick();
    n_checks++;
    if (obs !== O_FETCH_WAIT) begin
      n_err++;
      $display("FAIL first_fetch: got %h expected %h", obs, O_FETCH_WAIT);
    end
    fetch_decode(16'h6281);
    n_checks++;
    if (obs !== O_RD_WAIT) begin
      n_err++;
      $display("FAIL ldr_rd_state: got %h expected %h", obs, O_RD_WAIT);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (obs !== O_ZERO) begin
      n_err++;
      $display("FAIL rst_mid_rd: got %h expected %h", obs, O_ZERO);
    end
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (obs !== O_ZERO) begin
      n_err++;
      $display("FAIL rst_release: got %h expected %h", obs, O_ZERO);
    end
    tick();
    n_checks++;
    if (obs !== O_FETCH_WAIT) begin
      n_err++;
      $display("FAIL fetch_after_release: got %h expected %h", obs, O_FETCH_WAIT);
    end
  endtask

  // Back-to-back ALU, branch and jump instructions, checked in EXEC
  task automatic test_back_to_back();
    logic [15:0] t_instr [8];
    logic [2:0]  t_nzp   [8];
    logic [14:0] t_exp   [8];
    t_instr = '{16'h1261, 16'h5042, 16'h927F, 16'h0402, 16'h0402, 16'h0E00, 16'h0E00, 16'hC1C0};
    t_nzp   = '{3'b000,   3'b000,   3'b000,   3'b010,   3'b001,   3'b000,   3'b100,   3'b000};
    t_exp   = '{15'h1060, 15'h0260, 15'h0460, 15'h2080, 15'h2000, 15'h2000, 15'h2080, 15'h4080};
    do_reset();
    tick();
    for (int k = 0; k < 8; k++) begin
      nzp = t_nzp[k];
      fetch_decode(t_instr[k]);
      n_checks++;
      if (obs !== t_exp[k]) begin
        n_err++;
        $display("FAIL exec_%0d_%h: got %h expected %h", k, t_instr[k], obs, t_exp[k]);
      end
      tick();
    end
    n_checks++;
    if (obs !== O_FETCH_WAIT) begin
      n_err++;
      $display("FAIL fetch_after_exec: got %h expected %h", obs, O_FETCH_WAIT);
    end
  endtask

  // LDR with ready held low for 5 cycles and then raised
  task automatic test_ldr_wait();
    do_reset();
    tick();
    fetch_decode(16'h6281);
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++;
      if (obs !== O_RD_WAIT) begin
        n_err++;
        $display("FAIL ldr_wait_%0d: got %h expected %h", k, obs, O_RD_WAIT);
      end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    n_checks++;
    if (obs !== O_RD_DONE) begin
      n_err++;
      $display("FAIL ldr_ready: got %h expected %h", obs, O_RD_DONE);
    end
    tick();
    n_checks++;
    if (obs !== O_FETCH_DONE) begin
      n_err++;
      $display("FAIL ldr_next_fetch: got %h expected %h", obs, O_FETCH_DONE);
    end
  endtask

  // Store timeout on the 4-cycle instance, then a completion on the last allowed cycle
  task automatic test_timeout();
    do_reset();
    tick();
    fetch_decode(16'h3000);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (obs4 !== O_WR) begin
        n_err++;
        $display("FAIL st_wait_%0d: got %h expected %h", k, obs4, O_WR);
      end
      tick();
    end
    n_checks++;
    if (obs4 !== O_FAULT || obs !== O_WR) begin
      n_err++;
      $display("FAIL st_timeout: got %h/%h expected %h/%h", obs4, obs, O_FAULT, O_WR);
    end
    mem_ready = 1'b1;
    tick();
    n_checks++;
    if (obs4 !== O_FAULT) begin
      n_err++;
      $display("FAIL timeout_sticky: got %h expected %h", obs4, O_FAULT);
    end

    do_reset();
    tick();
    fetch_decode(16'h7000);
    for (int k = 0; k < 3; k++) begin
      tick();
    end
    mem_ready = 1'b1;
    #1;
    n_checks++;
    if (obs4 !== O_WR) begin
      n_err++;
      $display("FAIL str_ready_last: got %h expected %h", obs4, O_WR);
    end
    tick();
    mem_ready = 1'b0;
    #1;
    n_checks++;
    if (obs4 !== O_FETCH_WAIT) begin
      n_err++;
      $display("FAIL str_completed: got %h expected %h", obs4, O_FETCH_WAIT);
    end
  endtask

  // TRAP halts, and illegal opcodes fault; both states persist until rst
  task automatic test_halt_fault();
    logic [15:0] t_instr [3];
    logic [14:0] t_exp   [3];
    t_instr = '{16'hF025, 16'hD000, 16'h8000};
    t_exp   = '{O_HALT,   O_FAULT,  O_FAULT};
    for (int k = 0; k < 3; k++) begin
      do_reset();
      tick();
      fetch_decode(t_instr[k]);
      for (int c = 0; c < 3; c++) begin
        mem_ready = c[0];
        #1;
        n_checks++;
        if (obs !== t_exp[k]) begin
          n_err++;
          $display("FAIL terminal_%h_%0d: got %h expected %h", t_instr[k], c, obs, t_exp[k]);
        end
        tick();
      end
    end
    do_reset();
    n_checks++;
    if (obs !== O_ZERO) begin
      n_err++;
      $display("FAIL terminal_cleared: got %h expected %h", obs, O_ZERO);
    end
  endtask

  initial begin
    rst       = 1'b1;
    instr     = 16'h0000;
    nzp       = 3'b000;
    mem_ready = 1'b0;
    test_reset();
    test_back_to_back();
    test_ldr_wait();
    test_timeout();
    test_halt_fault();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
